// File: rtl/muldiv_hilo_unit.sv
// Radix-2 shift-add multiply unit with architectural HI/LO registers and writeback mux.
// Optional MULDIV_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.

package alu_pkg;
  typedef enum logic [3:0] {
    C_ADD,
    C_ADD_U,
    C_SUB,
    C_SUB_U,
    C_AND,
    C_OR,
    C_XOR,
    C_NOR,
    C_SLT,
    C_SLT_U,
    C_SLL,
    C_SRL,
    C_SRA,
    C_MULT,
    C_MUL_U,
    C_LUI
  } alu_sel_t;
endpackage

module muldiv_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  alu_pkg::alu_sel_t  opsel,
  input  logic               hi_en,
  input  logic               lo_en,
  input  logic [1:0]         alu_lo_hi,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   rt_data,
  input  logic [WIDTH-1:0]   alu_out,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out,
  output logic               busy,
  output logic               done,
  output logic               stall
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic                 neg_q;
  logic [CntW-1:0]      cnt_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q;

  logic                 launch, is_signed, last_iter;
  logic [WIDTH-1:0]     rs_mag, rt_mag, mplier_shr;
  logic [2*WIDTH-1:0]   acc_sum, product;
  logic [CntW-1:0]      cnt_inc;

  always_comb begin
    is_signed  = (opsel == alu_pkg::C_MULT);
    launch     = start && hi_en && lo_en &&
                 ((opsel == alu_pkg::C_MULT) || (opsel == alu_pkg::C_MUL_U));
    rs_mag     = (is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    rt_mag     = (is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    // The completing edge must fold in its own partial product before the sign fix-up.
    acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
    product    = neg_q ? -acc_sum : acc_sum;
    mplier_shr = mplier_q >> 1;
    cnt_inc    = cnt_q + 1'b1;
`ifdef MULDIV_EARLY_TERM_EN
    last_iter  = (mplier_shr == '0) || (cnt_inc == CntW'(WIDTH));
`else
    last_iter  = (cnt_inc == CntW'(WIDTH));
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (launch) state_d = StBusy;
      StBusy: if (last_iter) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy   = (state_q == StBusy);
    done   = done_q;
    hi_out = hi_q;
    lo_out = lo_q;
    stall  = busy && (alu_lo_hi != 2'b00);
    unique case (alu_lo_hi)
      2'b01:   result = lo_q;
      2'b10:   result = hi_q;
      default: result = alu_out;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (launch) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, rs_mag};
            mplier_q <= rt_mag;
            neg_q    <= is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            cnt_q    <= '0;
          end
        end
        StBusy: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_shr;
          cnt_q    <= cnt_inc;
          if (last_iter) begin
            {hi_q, lo_q} <= product;
            done_q       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
